dac_drive_capture: RTL and testbench
====================================

# dac_drive_capture

Receive-side monitor for the feed-forward DAC drive bus. Snoops the 13-bit DAC word and its DAC clock-enable strobe, latches one sample per strobe rising edge into an on-chip buffer, and reports per-pulse statistics (count, peak magnitude, saturation). The host reads the buffer back between pulses. It sits beside the DAC output registers, is clocked by the same processing clock, and provides loop-closure diagnostics for the drive path.

## Interface
- ADDR_W, 8: buffer address width; depth = 2^ADDR_W samples.
- TIMEOUT, 8: idle cycles without a strobe edge that end a frame; legal range is 3 to 255.
- clk  in  1  processing clock, same domain as the DAC driver.
- rst  in  1  reset, asynchronous, active-high.
- dac_din  in  13  signed DAC word, two's complement.
- dac_en  in  1  DAC clock-enable strobe; rising edge marks a valid word.
- arm  in  1  single-cycle pulse that arms capture for the next frame.
- abort  in  1  single-cycle pulse that returns the block to IDLE.
- rd_addr  in  ADDR_W  host readback address.
- rd_data  out  13  signed sample at rd_addr.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- sample_count  out  ADDR_W+1  words captured in the current or last frame.
- peak_abs  out  13  unsigned max |sample| over the frame.
- sat_flag  out  1  a sample equal to +4095 or -4096 was captured.
- overflow  out  1  a strobe arrived while the buffer was full.

## Operation
- Edge detect: register dac_en and dac_din once (en_q, din_q). A strobe event is `dac_en & ~en_q`. The sample value is the registered dac_din from the same cycle as the edge. The driver holds the word for 2 cycles, so the value is stable.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: on arm, clear sample_count, peak_abs, sat_flag and overflow, then go to ARMED.
- ARMED: the first strobe event writes address 0 and moves to CAPTURE.
- CAPTURE: each strobe event writes at address sample_count, then increments sample_count.
  - The idle counter resets on every event.
  - When the idle counter reaches TIMEOUT, go to DONE.
  - A strobe event when sample_count = 2^ADDR_W sets overflow, is not written, and moves to DONE.
- DONE: hold all results. arm re-arms exactly as from IDLE.
- abort has priority over arm and over every transition. It goes to IDLE and leaves the results and buffer contents untouched.
- arm while in ARMED or CAPTURE is ignored.
- The trailing clear word (value 0 with a strobe) is captured like any other word.
- Arithmetic:
  - abs(x) = x<0 ? -x : x, computed in 13 bits unsigned; -4096 maps to 4096.
  - peak_abs updates with max(peak_abs, abs) on each written sample.
  - sat_flag is sticky within a frame.

## Timing
- Reset values: rd_data 0, busy 0, done 0, sample_count 0, peak_abs 0, sat_flag 0, overflow 0. State is IDLE, en_q is 0 and the idle counter is 0. Buffer contents are undefined.
- Pipeline from the dac_en rising edge at pin (cycle N):
  - cycle N+1: event detected, write address presented;
  - cycle N+2: RAM written, and sample_count, peak_abs and sat_flag updated.
- State transitions take effect the cycle after their cause. busy and done are registered decodes of state.
- Readback: rd_data is valid 1 cycle after rd_addr, registered RAM output.
- Readback during CAPTURE is permitted. A same-address read/write collision returns the old data.
- The DONE transition on timeout occurs TIMEOUT+1 cycles after the last event detection.
- Reset asserted mid-frame forces all of the above immediately and asynchronously. Capture resumes only after a new arm.

## Structure
- Shared package dac_drive_pkg:
  - state enum cap_state_t {IDLE, ARMED, CAPTURE, DONE};
  - DAC_W = 13, DAC_MAX = 4095, DAC_MIN = -4096.
- Sub-module dac_capture_ram: simple dual-port RAM with one write port and one registered read port, both on clk, depth 2^ADDR_W, 13 bits wide, no reset.
- Top level contains the edge detector, the FSM, the idle counter and the statistics registers.

## Test plan
- Arm, then 10 strobes with values 1..10 at period 2 cycles, then silence:
  - done asserts TIMEOUT+1 cycles after the last event;
  - sample_count = 10, peak_abs = 10, sat_flag = 0;
  - rd_addr 0..9 returns 1..10.
- Frame containing -4096, 4095 and -3: peak_abs = 4096 and sat_flag = 1.
- ADDR_W=4, arm, 20 strobes: sample_count = 16, overflow = 1, done = 1; addresses 0..15 hold the first 16 values.
- Strobes before arm are ignored. Arm, then abort after 3 events: state is IDLE, sample_count = 3, busy = 0.
- rst asserted mid-CAPTURE: all outputs are 0 immediately. A subsequent frame without arm captures nothing.
- dac_en held high for 5 cycles counts as one event only. A 1-cycle gap between highs counts as two events.

Source files
------------

// File: rtl/dac_drive_pkg.sv
// Shared types and constants for the DAC drive-bus capture monitor.
// Contents: capture FSM state enum, DAC word width and the two saturation
// codes, plus a magnitude helper used by the peak tracker.
package dac_drive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int DAC_W = 13;
  localparam logic signed [DAC_W-1:0] DAC_MAX = 13'sh0FFF;  // +4095
  localparam logic signed [DAC_W-1:0] DAC_MIN = 13'sh1000;  // -4096

  // Magnitude as a 13-bit unsigned value. -4096 negates to the bit pattern
  // 1_0000_0000_0000, which read unsigned is exactly 4096.
  function automatic logic [DAC_W-1:0] dac_abs(input logic signed [DAC_W-1:0] x);
    logic [DAC_W-1:0] ux;
    ux = x;
    return x[DAC_W-1] ? (~ux + 13'd1) : ux;
  endfunction

endpackage

// File: rtl/dac_capture_ram.sv
// Sample buffer for the DAC capture monitor: simple dual-port RAM with one
// synchronous write port and one registered read port, both on clk.
// Ports:
//   clk      processing clock
//   rst      async active-high, clears only the read-data register
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, one cycle after raddr_i
// The array itself is never reset. A read of the address being written in
// the same cycle returns the old contents.
module dac_capture_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dac_drive_capture.sv
// Receive-side monitor for the feed-forward DAC drive bus. Snoops the DAC
// word and its clock-enable strobe, captures one sample per strobe rising
// edge into a buffer, and keeps per-frame count / peak |x| / saturation /
// overflow statistics for host readback.
// Ports:
//   clk, rst                 clock, async active-high reset
//   dac_din, dac_en          snooped DAC word (signed) and enable strobe
//   arm, abort               single-cycle control pulses from the host
//   rd_addr / rd_data        buffer readback, one cycle latency
//   busy, done               registered decodes of the capture state
//   sample_count, peak_abs   frame statistics
//   sat_flag, overflow       sticky frame flags
//   state_dbg                current FSM state, for observation only
//
// Strobe semantics: there is no ready; a word is offered whenever dac_en
// goes from 0 to 1, and the word sampled in that same cycle is the one
// captured. Holding dac_en high never produces more than one word.
module dac_drive_capture
  import dac_drive_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DAC_W-1:0]  dac_din,
  input  logic              dac_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DAC_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count,
  output logic [DAC_W-1:0]  peak_abs,
  output logic              sat_flag,
  output logic              overflow,
  output cap_state_t        state_dbg
);

  // Edge detector: register the strobe and word, then register the event
  // so that the write cycle sees a stable word alongside its event.
  logic                    en_q, ev_q;
  logic signed [DAC_W-1:0] din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= 1'b0;
      din_q <= '0;
      ev_q  <= 1'b0;
    end else begin
      en_q  <= dac_en;
      din_q <= dac_din;
      ev_q  <= dac_en & ~en_q;
    end
  end

  cap_state_t       state_q, state_d;
  logic [7:0]       idle_q, idle_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic [DAC_W-1:0] peak_q, peak_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clear_c, wr_en_c, ovf_set_c;

  logic             full;
  logic             timeout_hit;
  logic [DAC_W-1:0] sample_abs;
  logic             sample_sat;

  // Count MSB set means all 2^ADDR_W slots are used.
  assign full        = cnt_q[ADDR_W];
  // idle_q lags the cycle count by one, so matching TIMEOUT-1 lands the
  // DONE state exactly TIMEOUT+1 cycles after the last detected event.
  assign timeout_hit = (state_q == CAPTURE) & ~ev_q & (idle_q == 8'(TIMEOUT - 1));
  assign sample_abs  = dac_abs(din_q);
  assign sample_sat  = (din_q == DAC_MAX) | (din_q == DAC_MIN);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (ev_q) state_d = CAPTURE;
        CAPTURE: if ((ev_q & full) | timeout_hit) state_d = DONE;
        DONE:    if (arm) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM: outputs / datapath controls
  always_comb begin
    clear_c   = ~abort & arm & ((state_q == IDLE) | (state_q == DONE));
    wr_en_c   = ~abort & ev_q & ((state_q == ARMED) | (state_q == CAPTURE)) & ~full;
    ovf_set_c = ~abort & ev_q & (state_q == CAPTURE) & full;
    busy_d    = (state_d == ARMED) | (state_d == CAPTURE);
    done_d    = (state_d == DONE);
  end

  // Statistics and idle counter next-state
  always_comb begin
    cnt_d  = cnt_q;
    peak_d = peak_q;
    sat_d  = sat_q;
    ovf_d  = ovf_q;
    if (clear_c) begin
      cnt_d  = '0;
      peak_d = '0;
      sat_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (wr_en_c) begin
        cnt_d = cnt_q + 1'b1;
        if (sample_abs > peak_q) peak_d = sample_abs;
        if (sample_sat) sat_d = 1'b1;
      end
      if (ovf_set_c) ovf_d = 1'b1;
    end
    idle_d = ((state_q == CAPTURE) & ~ev_q) ? idle_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      cnt_q  <= '0;
      peak_q <= '0;
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  dac_capture_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DAC_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en_c),
    .waddr_i(cnt_q[ADDR_W-1:0]),
    .wdata_i(din_q),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = cnt_q;
  assign peak_abs     = peak_q;
  assign sat_flag     = sat_q;
  assign overflow     = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_dac_drive_capture.sv
module tb_dac_drive_capture;
  import dac_drive_pkg::*;

  localparam int TO = 8;

  localparam int S_RD1 = 0, S_BUSY1 = 1, S_DONE1 = 2, S_CNT1 = 3, S_PEAK1 = 4,
                 S_SAT1 = 5, S_OVF1 = 6, S_ST1 = 7, S_RD2 = 8, S_CNT2 = 9,
                 S_OVF2 = 10, S_DONE2 = 11, S_BUSY2 = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [12:0] dac_din;
  logic        dac_en;
  logic        arm1, abort1, arm2, abort2;
  logic [7:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [12:0] rd_data1, rd_data2, peak1, peak2;
  logic        busy1, done1, sat1, ovf1, busy2, done2, sat2, ovf2;
  logic [8:0]  cnt1;
  logic [4:0]  cnt2;
  cap_state_t  st1, st2;

  dac_drive_capture #(.ADDR_W(8), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rst(rst), .dac_din(dac_din), .dac_en(dac_en),
    .arm(arm1), .abort(abort1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .sample_count(cnt1), .peak_abs(peak1),
    .sat_flag(sat1), .overflow(ovf1), .state_dbg(st1)
  );

  dac_drive_capture #(.ADDR_W(4), .TIMEOUT(TO)) u_dut2 (
    .clk(clk), .rst(rst), .dac_din(dac_din), .dac_en(dac_en),
    .arm(arm2), .abort(abort2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .busy(busy2), .done(done2), .sample_count(cnt2), .peak_abs(peak2),
    .sat_flag(sat2), .overflow(ovf2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  int          lat_q[$];
  logic        snap = 1'b0;
  logic        done1_prev = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_en_cyc = 0;

  function automatic logic [31:0] act(int sel);
    case (sel)
      S_RD1:   return 32'(rd_data1);
      S_BUSY1: return 32'(busy1);
      S_DONE1: return 32'(done1);
      S_CNT1:  return 32'(cnt1);
      S_PEAK1: return 32'(peak1);
      S_SAT1:  return 32'(sat1);
      S_OVF1:  return 32'(ovf1);
      S_ST1:   return 32'(st1);
      S_RD2:   return 32'(rd_data2);
      S_CNT2:  return 32'(cnt2);
      S_OVF2:  return 32'(ovf2);
      S_DONE2: return 32'(done2);
      S_BUSY2: return 32'(busy2);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      S_RD1:   return "rd_data";
      S_BUSY1: return "busy";
      S_DONE1: return "done";
      S_CNT1:  return "sample_count";
      S_PEAK1: return "peak_abs";
      S_SAT1:  return "sat_flag";
      S_OVF1:  return "overflow";
      S_ST1:   return "state";
      S_RD2:   return "rd_data(aw4)";
      S_CNT2:  return "sample_count(aw4)";
      S_OVF2:  return "overflow(aw4)";
      S_DONE2: return "done(aw4)";
      S_BUSY2: return "busy(aw4)";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compares queued expectations when a snapshot is presented, and
  // checks the cycle at which each done rising edge of the main DUT occurs.
  always @(negedge clk) begin : monitor
    logic [31:0] e, a;
    int          s, el;
    if (snap) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        a = act(s);
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h (t=%0t)", sel_name(s), a, e, $time);
        end
      end
    end
    if (done1 && !done1_prev) begin
      n_checks++;
      if (lat_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_latency: unexpected done rise at cycle %0d", cyc);
      end else begin
        el = lat_q.pop_front();
        if (cyc != el) begin
          n_fail++;
          $display("FAIL done_latency: rose at cycle %0d expected %0d", cyc, el);
        end
      end
    end
    done1_prev = done1;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising clock edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int sel, input logic [31:0] exp);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
  endtask

  task automatic snap_now();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic strobe(input logic [12:0] v);
    dac_din = v;
    dac_en  = 1'b1;
    last_en_cyc = cyc;
    tick();
    dac_en = 1'b0;
    tick();
  endtask

  task automatic pulse_arm1();
    arm1 = 1'b1;
    tick();
    arm1 = 1'b0;
  endtask

  task automatic pulse_abort1();
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
  endtask

  task automatic read1(input logic [7:0] a, input logic [12:0] exp);
    rd_addr1 = a;
    tick();
    check(S_RD1, 32'(exp));
    snap_now();
  endtask

  task automatic read2(input logic [3:0] a, input logic [12:0] exp);
    rd_addr2 = a;
    tick();
    check(S_RD2, 32'(exp));
    snap_now();
  endtask

  task automatic check_stats1(input int cnt, input int peak, input int sat,
                              input int ovf, input int busy, input int dn, input int st);
    check(S_CNT1, 32'(cnt));
    check(S_PEAK1, 32'(peak));
    check(S_SAT1, 32'(sat));
    check(S_OVF1, 32'(ovf));
    check(S_BUSY1, 32'(busy));
    check(S_DONE1, 32'(dn));
    check(S_ST1, 32'(st));
    snap_now();
  endtask

  // Watchdog: the run is a few hundred cycles long.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    dac_din = '0; dac_en = 1'b0;
    arm1 = 1'b0; abort1 = 1'b0; arm2 = 1'b0; abort2 = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    tick();
    // Reset state
    check(S_RD1, 0);
    check_stats1(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // Strobes 1..10 at period 2, then silence
    pulse_arm1();
    check(S_BUSY1, 1);
    check(S_ST1, 1);
    snap_now();
    for (int i = 1; i <= 10; i++) strobe(13'(i));
    lat_q.push_back(last_en_cyc + TO + 2);
    repeat (14) tick();
    check_stats1(10, 10, 0, 0, 0, 1, 3);
    for (int i = 0; i < 10; i++) read1(8'(i), 13'(i + 1));

    // Saturating frame: -4096, +4095, -3
    pulse_arm1();
    strobe(13'h1000);
    strobe(13'h0FFF);
    strobe(13'h1FFD);
    lat_q.push_back(last_en_cyc + TO + 2);
    repeat (14) tick();
    check_stats1(3, 4096, 1, 0, 0, 1, 3);
    read1(8'd0, 13'h1000);
    read1(8'd1, 13'h0FFF);
    read1(8'd2, 13'h1FFD);

    // Small buffer: 20 strobes into 16 slots
    arm2 = 1'b1;
    tick();
    arm2 = 1'b0;
    for (int i = 0; i < 20; i++) strobe(13'(100 + i));
    tick();
    check(S_CNT2, 16);
    check(S_OVF2, 1);
    check(S_DONE2, 1);
    check(S_BUSY2, 0);
    snap_now();
    for (int i = 0; i < 16; i++) read2(4'(i), 13'(100 + i));

    // Abort from DONE keeps results; strobes in IDLE are ignored
    pulse_abort1();
    check_stats1(3, 4096, 1, 0, 0, 0, 0);
    strobe(13'd5);
    strobe(13'd6);
    strobe(13'd7);
    repeat (3) tick();
    check(S_CNT1, 3);
    check(S_ST1, 0);
    snap_now();
    pulse_arm1();
    check_stats1(0, 0, 0, 0, 1, 0, 1);
    strobe(13'd21);
    strobe(13'h1FEA);  // -22
    strobe(13'd23);
    pulse_abort1();
    check_stats1(3, 23, 0, 0, 0, 0, 0);
    read1(8'd0, 13'd21);
    read1(8'd1, 13'h1FEA);
    read1(8'd2, 13'd23);

    // Reset mid-CAPTURE clears everything at once
    pulse_arm1();
    strobe(13'd1);
    strobe(13'd2);
    rd_addr1 = 8'd1;
    tick();
    rst = 1'b1;
    check(S_RD1, 0);
    check_stats1(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    strobe(13'd9);
    strobe(13'd9);
    strobe(13'd9);
    repeat (12) tick();
    check_stats1(0, 0, 0, 0, 0, 0, 0);

    // Held-high enable is one event; a 1-cycle gap gives two events
    pulse_arm1();
    dac_din = 13'd50;
    dac_en  = 1'b1;
    repeat (5) tick();
    dac_en = 1'b0;
    tick();
    dac_din = 13'd60;
    dac_en  = 1'b1;
    tick();
    dac_en = 1'b0;
    tick();
    dac_din = 13'd70;
    dac_en  = 1'b1;
    last_en_cyc = cyc;
    tick();
    dac_en = 1'b0;
    tick();
    lat_q.push_back(last_en_cyc + TO + 2);
    repeat (14) tick();
    check_stats1(3, 70, 0, 0, 0, 1, 3);
    read1(8'd0, 13'd50);
    read1(8'd1, 13'd60);
    read1(8'd2, 13'd70);

    // Any done rise that never happened is a failure
    repeat (3) tick();
    while (lat_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_latency: no done rise, expected at cycle %0d", lat_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
